// File: rtl/pcie_init_sequencer.sv
// Power-up sequencer for the PCIe TL clock domain: qualifies synchronised init flags, switches the
// NGMUX to the 125 MHz clock, then releases staged downstream resets and supervises the flags.
module pcie_init_sequencer #(
  parameter int unsigned          NUM_BANKS      = 3,
  parameter logic [NUM_BANKS-1:0] CALIB_MASK     = '1,
  parameter int unsigned          STABLE_CYCLES  = 16,
  parameter int unsigned          SWITCH_CYCLES  = 8,
  parameter int unsigned          NUM_RESETS     = 4,
  parameter int unsigned          RELEASE_GAP    = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 1000
) (
  input  logic                  CLK_125MHz,
  input  logic                  RESET,
  input  logic                  FABRIC_POR_N,
  input  logic                  DEVICE_INIT_DONE,
  input  logic                  PCIE_INIT_DONE,
  input  logic                  BANK_4_VDDI_STATUS,
  input  logic [NUM_BANKS-1:0]  BANK_CALIB_STATUS,
  output logic                  TL_CLK_SEL,
  output logic                  CALIB_DONE,
  output logic [NUM_RESETS-1:0] RESET_N_OUT,
  output logic                  READY,
  output logic                  TIMEOUT_ERR,
  output logic [2:0]            INIT_STATE
);

  localparam int unsigned NumSync = 4 + NUM_BANKS;
  localparam int unsigned MaxA    = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES
                                                                     : STABLE_CYCLES;
  localparam int unsigned MaxB    = (SWITCH_CYCLES > RELEASE_GAP) ? SWITCH_CYCLES : RELEASE_GAP;
  localparam int unsigned MaxCnt  = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW    = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StWaitInit = 3'd0,
    StStable   = 3'd1,
    StSwitch   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4,
    StFault    = 3'd5
  } state_e;

  logic [NumSync-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  calib_q, calib_d, all_ok_q, all_ok_d;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_RESETS-1:0] rst_n_q, rst_n_d;
  logic                  sel_q, sel_d, ready_q, ready_d, timeout_q, timeout_d;

  always_comb begin
    sync1_d  = {FABRIC_POR_N, DEVICE_INIT_DONE, PCIE_INIT_DONE, BANK_4_VDDI_STATUS,
                BANK_CALIB_STATUS};
    sync2_d  = sync1_q;
    // Masked-out banks read as done, so an all-zero mask yields 1.
    calib_d  = &(sync2_q[NUM_BANKS-1:0] | ~CALIB_MASK);
    all_ok_d = (&sync2_q[NumSync-1:NUM_BANKS]) & calib_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    rst_n_d   = rst_n_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StWaitInit: begin
        if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) timeout_d = 1'b1;
        if (all_ok_q) begin
          state_d = StStable;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        if (!all_ok_q) begin
          state_d = StWaitInit;
        end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
          state_d = StSwitch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSwitch: begin
        if (cnt_q == CntW'(SWITCH_CYCLES - 1)) begin
          state_d = StRelease;
          rst_n_d = NUM_RESETS'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (!all_ok_q) begin
          state_d = StFault;
          rst_n_d = '0;
        end else if (&rst_n_q) begin
          state_d = StRun;
        end else if (cnt_q == CntW'(RELEASE_GAP - 1)) begin
          // Resets release as a thermometer code, lowest bit first.
          rst_n_d = (rst_n_q << 1) | NUM_RESETS'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!all_ok_q) begin
          state_d = StFault;
          rst_n_d = '0;
        end
      end
      StFault: state_d = StWaitInit;
      default: begin
        state_d = StWaitInit;
        rst_n_d = '0;
      end
    endcase
    // The NGMUX is never switched back: reverting it is not glitch-safe.
    sel_d   = sel_q | (state_d == StSwitch);
    ready_d = (state_d == StRun);
  end

  always_ff @(posedge CLK_125MHz) begin
    if (RESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      calib_q   <= 1'b0;
      all_ok_q  <= 1'b0;
      state_q   <= StWaitInit;
      cnt_q     <= '0;
      rst_n_q   <= '0;
      sel_q     <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      calib_q   <= calib_d;
      all_ok_q  <= all_ok_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_n_q   <= rst_n_d;
      sel_q     <= sel_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
    end
  end

  assign TL_CLK_SEL  = sel_q;
  assign CALIB_DONE  = calib_q;
  assign RESET_N_OUT = rst_n_q;
  assign READY       = ready_q;
  assign TIMEOUT_ERR = timeout_q;
  assign INIT_STATE  = state_q;

endmodule

// File: tb/tb_pcie_init_sequencer.sv
// Bench for pcie_init_sequencer: timeline table, hand-written corner sequences and random
// flag activity, all compared against a cycle-level reference model.
module tb_pcie_init_sequencer;

  localparam int unsigned NB = 3;
  localparam logic [NB-1:0] MASK = 3'b011;
  localparam int SC = 16, SWC = 8, NR = 4, GAP = 4, TO = 1000;
  localparam int PWait = 0, PStable = 1, PSwitch = 2, PRelease = 3, PRun = 4, PFault = 5;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic          rst, por_n, dev, pcie, vddi;
  logic [NB-1:0] bank;
  logic          sel, calib, ready, tout;
  logic [NR-1:0] rstn;
  logic [2:0]    st;

  pcie_init_sequencer #(
    .NUM_BANKS(NB), .CALIB_MASK(MASK), .STABLE_CYCLES(SC), .SWITCH_CYCLES(SWC),
    .NUM_RESETS(NR), .RELEASE_GAP(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_125MHz(clk), .RESET(rst), .FABRIC_POR_N(por_n), .DEVICE_INIT_DONE(dev),
    .PCIE_INIT_DONE(pcie), .BANK_4_VDDI_STATUS(vddi), .BANK_CALIB_STATUS(bank),
    .TL_CLK_SEL(sel), .CALIB_DONE(calib), .RESET_N_OUT(rstn), .READY(ready),
    .TIMEOUT_ERR(tout), .INIT_STATE(st)
  );

  int vectors = 0, miscompares = 0, cyc = 0, base = 0;

  // Reference model: phase + age-in-phase; release count derived arithmetically from age.
  int m_ph = PWait, m_age = 0, m_nrel = 0;
  bit m_sel = 0, m_tout = 0, m_cal = 0;
  bit okq[$];
  bit calq[$];

  typedef struct {
    int         e;
    logic [2:0] st;
    logic       sel;
    logic [3:0] rstn;
    logic       rdy;
    logic       cal;
    logic       to;
  } vec_t;
  vec_t tbl[12];

  function automatic bit raw_calib();
    bit c = 1'b1;
    for (int i = 0; i < NB; i++) if (MASK[i] && !bank[i]) c = 1'b0;
    return c;
  endfunction

  function automatic logic [10:0] dut_vec();
    return {st, sel, rstn, ready, calib, tout};
  endfunction

  function automatic logic [10:0] exp_vec(logic [2:0] s, logic c, logic [3:0] r, logic y,
                                          logic ca, logic t);
    return {s, c, r, y, ca, t};
  endfunction

  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge#%0d: got st/sel/rstn/rdy/cal/to=%b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit okd, rc, raw_ok;
    rc     = raw_calib();
    raw_ok = por_n & dev & pcie & vddi & rc;
    if (rst) begin
      m_ph = PWait; m_age = 0; m_nrel = 0; m_sel = 0; m_tout = 0; m_cal = 0;
      okq  = '{1'b0, 1'b0, 1'b0};
      calq = '{1'b0, 1'b0};
      return;
    end
    okd   = okq.pop_front();
    okq.push_back(raw_ok);
    m_cal = calq.pop_front();
    calq.push_back(rc);
    case (m_ph)
      PWait: begin
        if (m_age + 1 >= TO) m_tout = 1;
        if (okd) begin m_ph = PStable; m_age = 0; end
        else m_age++;
      end
      PStable: begin
        if (!okd) begin m_ph = PWait; m_age = 0; end
        else if (m_age + 1 == SC) begin m_ph = PSwitch; m_age = 0; m_sel = 1; end
        else m_age++;
      end
      PSwitch: begin
        if (m_age + 1 == SWC) begin m_ph = PRelease; m_age = 0; m_nrel = 1; end
        else m_age++;
      end
      PRelease: begin
        if (!okd) begin m_ph = PFault; m_nrel = 0; end
        else if (m_nrel == NR) m_ph = PRun;
        else begin
          m_age++;
          m_nrel = 1 + m_age / GAP;
          if (m_nrel > NR) m_nrel = NR;
        end
      end
      PRun: if (!okd) begin m_ph = PFault; m_nrel = 0; end
      default: begin m_ph = PWait; m_age = 0; end
    endcase
  endtask

  task automatic step();
    logic [NR-1:0] r;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    r = NR'((1 << m_nrel) - 1);
    check("model", dut_vec(), exp_vec(3'(m_ph), m_sel, r, m_ph == PRun, m_cal, m_tout));
  endtask

  task automatic step_to(int e);
    while (cyc - base - 1 < e) step();
  endtask

  task automatic expect_at(int e, string name, logic [10:0] exp);
    step_to(e);
    check(name, dut_vec(), exp);
  endtask

  task automatic do_reset();
    rst = 1; por_n = 0; dev = 0; pcie = 0; vddi = 0; bank = '0;
    repeat (3) step();
  endtask

  // Releases reset and raises the flags; the next edge is edge 0. Bank 2 stays low (masked).
  task automatic go(bit d);
    rst = 0; por_n = 1; dev = d; pcie = 1; vddi = 1; bank = 3'b011;
    base = cyc;
  endtask

  function automatic bit flip(bit v);
    if (v) return ($urandom_range(0, 199) != 0);
    return ($urandom_range(0, 3) == 0);
  endfunction

  initial begin
    tbl[0]  = '{1,  3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2,  3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3,  3'd1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{18, 3'd1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{19, 3'd2, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{26, 3'd2, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{27, 3'd3, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{30, 3'd3, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{31, 3'd3, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{35, 3'd3, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{39, 3'd3, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{40, 3'd4, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0};

    // Reset state, then nominal start-up timeline.
    do_reset();
    check("reset_state", dut_vec(), exp_vec(3'd0, 0, 4'h0, 0, 0, 0));
    go(1);
    for (int i = 0; i < 12; i++) begin
      step_to(tbl[i].e);
      check($sformatf("nominal_e%0d", tbl[i].e), dut_vec(),
            exp_vec(tbl[i].st, tbl[i].sel, tbl[i].rstn, tbl[i].rdy, tbl[i].cal, tbl[i].to));
    end

    // Fault in RUN, then full re-sequence with the clock select held.
    step_to(49);
    vddi = 0;
    expect_at(52, "run_before_fault", exp_vec(3'd4, 1, 4'hF, 1, 1, 0));
    expect_at(53, "run_fault",        exp_vec(3'd5, 1, 4'h0, 0, 1, 0));
    expect_at(54, "fault_to_wait",    exp_vec(3'd0, 1, 4'h0, 0, 1, 0));
    vddi = 1;
    expect_at(57, "rearm_wait",       exp_vec(3'd0, 1, 4'h0, 0, 1, 0));
    expect_at(58, "rearm_stable",     exp_vec(3'd1, 1, 4'h0, 0, 1, 0));
    expect_at(81, "rearm_switch_end", exp_vec(3'd2, 1, 4'h0, 0, 1, 0));
    expect_at(82, "rearm_release0",   exp_vec(3'd3, 1, 4'h1, 0, 1, 0));
    expect_at(95, "rearm_run",        exp_vec(3'd4, 1, 4'hF, 1, 1, 0));

    // Reset mid-RELEASE.
    do_reset();
    go(1);
    expect_at(31, "pre_reset_release", exp_vec(3'd3, 1, 4'h3, 0, 1, 0));
    rst = 1;
    expect_at(32, "reset_mid_release", exp_vec(3'd0, 0, 4'h0, 0, 0, 0));

    // Fault in RELEASE during the gap.
    do_reset();
    go(1);
    step_to(32);
    por_n = 0;
    expect_at(35, "release_pre_fault", exp_vec(3'd3, 1, 4'h7, 0, 1, 0));
    expect_at(36, "release_fault",     exp_vec(3'd5, 1, 4'h0, 0, 1, 0));
    expect_at(37, "release_fault_wait", exp_vec(3'd0, 1, 4'h0, 0, 1, 0));

    // One-cycle glitch while STABLE.
    do_reset();
    go(1);
    step_to(9);
    pcie = 0;
    step_to(10);
    pcie = 1;
    expect_at(12, "glitch_still_stable", exp_vec(3'd1, 0, 4'h0, 0, 1, 0));
    expect_at(13, "glitch_wait",         exp_vec(3'd0, 0, 4'h0, 0, 1, 0));
    expect_at(14, "glitch_restable",     exp_vec(3'd1, 0, 4'h0, 0, 1, 0));
    expect_at(29, "glitch_no_early_sel", exp_vec(3'd1, 0, 4'h0, 0, 1, 0));
    expect_at(30, "glitch_switch",       exp_vec(3'd2, 1, 4'h0, 0, 1, 0));

    // Timeout, with the flag rising on the very edge the timeout completes.
    do_reset();
    go(0);
    step_to(995);
    dev = 1;
    expect_at(998,  "timeout_pre",      exp_vec(3'd0, 0, 4'h0, 0, 1, 0));
    expect_at(999,  "timeout_and_rise", exp_vec(3'd1, 0, 4'h0, 0, 1, 1));
    expect_at(1036, "timeout_sticky",   exp_vec(3'd4, 1, 4'hF, 1, 1, 1));

    // Random flag activity against the model.
    do_reset();
    go(1);
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else rst = ($urandom_range(0, 799) == 0);
      por_n   = flip(por_n);
      dev     = flip(dev);
      pcie    = flip(pcie);
      vddi    = flip(vddi);
      bank[0] = flip(bank[0]);
      bank[1] = flip(bank[1]);
      bank[2] = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
